// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment scan controller: active-high
// segment patterns, segment bit positions and the output polarity helper.
package fnd_pkg;

    // Bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} segment bus
    localparam int SEG_POS_A  = 0;
    localparam int SEG_POS_G  = 6;
    localparam int SEG_POS_DP = 7;

    // Active-high patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h7C;
    localparam logic [6:0] SEG_C    = 7'h39;
    localparam logic [6:0] SEG_D    = 7'h5E;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Map an active-high segment byte onto the pin polarity of the board
    function automatic logic [7:0] seg_polarity(input logic [7:0] seg,
                                                input logic       active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Nibble to active-high seven-segment pattern. Values above 9 show A-F
// when HEX_EN is set, otherwise a lone centre bar.
module bcd_to_seg
    import fnd_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    localparam logic HEX = (HEX_EN != 0);

    // Pure lookup; dash is the fall-back for every non-decimal value
    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = HEX ? SEG_A : SEG_DASH;
            4'hB: seg = HEX ? SEG_B : SEG_DASH;
            4'hC: seg = HEX ? SEG_C : SEG_DASH;
            4'hD: seg = HEX ? SEG_D : SEG_DASH;
            4'hE: seg = HEX ? SEG_E : SEG_DASH;
            4'hF: seg = HEX ? SEG_F : SEG_DASH;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed seven-segment scan controller. A slot prescaler walks a digit
// index across NUM_DIGITS; each slot opens with BLANK_CYC dark cycles to
// stop ghosting while the common lines swap, then lights one digit with the
// pattern captured at the start of the slot.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 2,
    parameter int HEX_EN     = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_blank_lz,
    output logic [NUM_DIGITS-1:0]     o_digit,
    output logic [7:0]                o_seg,
    output logic                      o_frame_tick
);

    localparam int   CNT_W   = $clog2(SCAN_DIV);
    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam logic OFF_LVL = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                idx;
    logic                            cnt_last;
    logic                            idx_last;

    logic [NUM_DIGITS-1:0][3:0]      nib;
    logic [NUM_DIGITS-1:0][6:0]      pat;
    logic [NUM_DIGITS-1:0]           lz_blank;
    logic                            all_zero;

    logic [6:0]                      snap_pat;
    logic                            snap_dp;
    logic                            snap_blank;

    logic [NUM_DIGITS-1:0]           dig_next;
    logic [7:0]                      seg_next;
    logic                            tick_next;

    assign nib      = i_bcd;
    assign cnt_last = (cnt == CNT_W'(SCAN_DIV - 1));
    assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));

    // One decoder per digit; the decoded pattern is what gets captured, so
    // the selected lane only needs a mux at snapshot time.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        bcd_to_seg #(.HEX_EN(HEX_EN)) u_dec (
            .nib (nib[g]),
            .seg (pat[g])
        );
    end

    // Leading-zero suppression: digit k goes dark when it and every digit
    // above it are zero. Digit 0 always shows so a zero value reads "0".
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero    = all_zero && (nib[k] == 4'h0);
            lz_blank[k] = i_blank_lz && all_zero;
        end
    end

    // Slot prescaler and digit index; disable parks both at zero so a
    // re-enable always restarts from digit 0 with a blank phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!i_en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Capture the selected digit at slot start so input changes mid-slot
    // cannot tear the displayed character.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_pat   <= '0;
            snap_dp    <= 1'b0;
            snap_blank <= 1'b0;
        end else if (i_en && (cnt == '0)) begin
            snap_pat   <= pat[idx];
            snap_dp    <= i_dp[idx];
            snap_blank <= lz_blank[idx];
        end
    end

    // Active-high view of the next output state; dp survives blanking.
    always_comb begin
        dig_next  = '0;
        seg_next  = '0;
        tick_next = i_en && cnt_last && idx_last;
        if (i_en && (cnt >= CNT_W'(BLANK_CYC))) begin
            dig_next = NUM_DIGITS'(1) << idx;
            seg_next[SEG_POS_DP]           = snap_dp;
            seg_next[SEG_POS_G:SEG_POS_A]  = snap_blank ? 7'h00 : snap_pat;
        end
    end

    // Registered pins; reset drives the "all off" level asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_digit      <= {NUM_DIGITS{OFF_LVL}};
            o_seg        <= seg_polarity(8'h00, OFF_LVL);
            o_frame_tick <= 1'b0;
        end else begin
            o_digit      <= dig_next ^ {NUM_DIGITS{OFF_LVL}};
            o_seg        <= seg_polarity(seg_next, OFF_LVL);
            o_frame_tick <= tick_next;
        end
    end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Parametrised multiplexed seven-segment (FND) scan controller. Time-multiplexes `NUM_DIGITS` BCD/hex nibbles onto a shared segment bus with a free-running digit scan, ghost-suppression blanking, leading-zero suppression and per-digit decimal points. It sits between the display-value logic and the board FND pins. It supersedes the fixed 2-bit, 4-digit combinational digit-select decoder: digit selection is now generated internally.

## Interface
- `NUM_DIGITS`, 4, number of digits; must be ≥ 2.
- `SCAN_DIV`, 100000, clock cycles per digit slot; must be > `BLANK_CYC`.
- `BLANK_CYC`, 2, all-off cycles at the start of each slot; must be ≥ 1.
- `HEX_EN`, 1, 1: nibbles 10–15 show A–F; 0: they show "-" (segment g only).
- `ACTIVE_LOW`, 1, 1: `o_digit` and `o_seg` are active-low (common anode).

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  scan enable.
- `i_bcd`  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant.
- `i_dp`  in  NUM_DIGITS  decimal point per digit.
- `i_blank_lz`  in  1  leading-zero suppression enable.
- `o_digit`  out  NUM_DIGITS  one-hot digit enable (polarity per `ACTIVE_LOW`).
- `o_seg`  out  8  `{dp,g,f,e,d,c,b,a}` (polarity per `ACTIVE_LOW`).
- `o_frame_tick`  out  1  one-cycle pulse, active-high, once per full scan.

## Operation
- **Slot counter** `cnt` runs 0..SCAN_DIV-1. At the terminal count it wraps to 0 and advances the digit index `idx`, which runs 0..NUM_DIGITS-1 and wraps to 0.
- **Snapshot:** when `cnt==0`, the nibble, dp bit and blank decision for `idx` are latched. Changes to `i_bcd`, `i_dp` or `i_blank_lz` mid-slot do not affect the current slot.
- **Leading-zero suppression:** digit k (k ≥ 1) is blanked when `i_blank_lz=1` and nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives all segments off, but its dp bit is still honoured.
- **Blank phase:** while `cnt < BLANK_CYC`, all digits and segments are off.
  - Otherwise, `o_digit` selects `idx` only and `o_seg` shows the decoded snapshot.
- **Decode, active-high:**
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - A–F: 77, 7C, 39, 5E, 79, 71.
  - `HEX_EN=0` with a value > 9: 40.
  - dp is bit 7.
  - `ACTIVE_LOW=1` inverts both `o_seg` and `o_digit`.
- **Frame tick:** `o_frame_tick` pulses for the cycle in which `idx` wraps from NUM_DIGITS-1 to 0.
- **Disable:** `i_en=0` synchronously clears `cnt` and `idx` and forces all outputs off from the next cycle.
  - On re-enable, scanning restarts at digit 0, beginning with a blank phase.

## Timing
- Reset (async assert, sync release): `cnt=0`, `idx=0`, snapshot cleared, `o_frame_tick=0`, all digits and segments off.
  - With `ACTIVE_LOW=1` that is `o_digit` all 1s and `o_seg=8'hFF`.
- `o_digit`, `o_seg` and `o_frame_tick` are registered. They reflect `cnt`/`idx` of the previous cycle, so latency is one cycle.
- First lit digit after reset release with `i_en=1`: digit 0 appears at cycle BLANK_CYC+1.
- Each digit is lit for SCAN_DIV-BLANK_CYC cycles. Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Reset mid-slot forces outputs off immediately, without waiting for a clock edge.
- `i_en` falling and the terminal count in the same cycle: disable wins and `idx` returns to 0. No frame tick is generated.

## Structure
- Package `fnd_pkg`:
  - segment-pattern constants `SEG_0`..`SEG_F` and `SEG_DASH`;
  - segment bit-position localparams;
  - function `seg_polarity`.
- Sub-module `bcd_to_seg`: combinational nibble plus `HEX_EN` to 7-bit active-high pattern.
- Top module contains the prescaler, index counter, snapshot, leading-zero logic and output registers.

## Test plan
Bench configuration: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1.
- Reset held, then released with `i_en=1` → `o_digit=4'b1111`, `o_seg=8'hFF` until cycle 3, then `o_digit=4'b1110`.
- `i_bcd=16'h1234`, `i_dp=0` → per slot, digits 0..3 show `o_seg` F9h... specifically 99h ("4"), B0h ("3"), A4h ("2"), F9h ("1"). `o_digit` steps 1110, 1101, 1011, 0111, each lit for 6 cycles after 2 blank cycles.
- `i_bcd=16'h0007`, `i_blank_lz=1`, `i_dp=4'b0100` → digit0 `o_seg=F8h`; digit1 `FFh`; digit2 `7Fh` (dp only); digit3 `FFh`. Then `i_bcd=0` → digit0 `C0h`.
- HEX_EN=1 with nibble Ah → `88h`; HEX_EN=0 with nibble Ah → `BFh`.
- `o_frame_tick` pulses exactly once every 32 cycles. Changing `i_bcd` at `cnt=4` leaves the current digit's `o_seg` unchanged until the next slot.
- `i_en=0` mid-slot → all off next cycle; re-enable → digit 0 lit after 2 blank cycles. Async reset mid-scan → outputs off immediately.
